pipe_hazard_ctrl: RTL and testbench

// Central stall/flush sequencer for the 5-stage LC-3b pipeline.

---
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline. Outputs are combinational (zero-cycle latency).
// Perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic [15:0]      br_target,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_exe,
  output logic             stall_exe_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             flush_exe_mem,
  output logic             flush_mem_wb,
  output logic             pc_redirect,
  output logic [15:0]      pc_target,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] squash_count
);

  typedef enum logic [1:0] {RUN, DWAIT, IDRAIN} state_t;

  state_t      state_q, state_d;
  logic        br_pend_q, br_pend_d;
  logic [15:0] tgt_q, tgt_d;
  logic        br_eff;
  logic [15:0] eff_tgt;

  always_comb begin
    state_d       = state_q;
    br_pend_d     = br_pend_q;
    tgt_d         = tgt_q;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_exe  = 1'b0;
    stall_exe_mem = 1'b0;
    stall_mem_wb  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_exe  = 1'b0;
    flush_exe_mem = 1'b0;
    flush_mem_wb  = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = br_target;
    // br_pend_q is only ever set while in DWAIT, so this is br_taken alone in RUN
    br_eff        = br_taken | br_pend_q;
    eff_tgt       = (br_pend_q && !br_taken) ? tgt_q : br_target;

    if (reset) begin
      state_d   = RUN;
      br_pend_d = 1'b0;
      tgt_d     = '0;
      pc_target = '0;
    end else begin
      case (state_q)
        IDRAIN: begin
          flush_if_id = 1'b1;
          if (imem_stall) begin
            stall_pc = 1'b1;
          end else begin
            pc_redirect = 1'b1;
            pc_target   = tgt_q;
            state_d     = RUN;
          end
        end
        default: begin
          if (dmem_stall) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_exe  = 1'b1;
            stall_exe_mem = 1'b1;
            flush_mem_wb  = 1'b1;
            state_d       = DWAIT;
            if (br_taken) begin
              br_pend_d = 1'b1;
              tgt_d     = br_target;
            end
          end else begin
            br_pend_d = 1'b0;
            state_d   = RUN;
            if (br_eff) begin
              flush_if_id   = 1'b1;
              flush_id_exe  = 1'b1;
              flush_exe_mem = 1'b1;
              if (imem_stall) begin
                // fetch in flight: park the target until the wrong-path word lands
                stall_pc = 1'b1;
                tgt_d    = eff_tgt;
                state_d  = IDRAIN;
              end else begin
                pc_redirect = 1'b1;
                pc_target   = eff_tgt;
              end
            end else if (load_use) begin
              stall_pc     = 1'b1;
              stall_if_id  = 1'b1;
              flush_id_exe = 1'b1;
            end else if (imem_stall) begin
              stall_pc    = 1'b1;
              flush_if_id = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      br_pend_q <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      br_pend_q <= br_pend_d;
      tgt_q     <= tgt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, squash_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (stall_pc)    stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (pc_redirect) squash_cnt_q <= squash_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign squash_count = squash_cnt_q;
`else
  assign stall_cycles = '0;
  assign squash_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written corner sequences, randomized model check.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int M_RUN = 0, M_DWAIT = 1, M_IDRAIN = 2;

  logic clk = 1'b0;
  logic reset, imem_stall, dmem_stall, load_use, br_taken;
  logic [15:0] br_target;
  logic stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb;
  logic flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb;
  logic pc_redirect;
  logic [15:0] pc_target;
  logic [CNT_W-1:0] stall_cycles, squash_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .load_use(load_use), .br_taken(br_taken), .br_target(br_target),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_exe(stall_id_exe),
    .stall_exe_mem(stall_exe_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_exe(flush_id_exe),
    .flush_exe_mem(flush_exe_mem), .flush_mem_wb(flush_mem_wb),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .stall_cycles(stall_cycles), .squash_count(squash_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pipeline registers indexed 0=PC,1=IF/ID,2=ID/EX,3=EX/MEM,4=MEM/WB
  int          m_mode = M_RUN;
  logic        m_pend = 1'b0;
  logic [15:0] m_tgt  = '0;
  int          m_stalls = 0, m_squash = 0;
  logic [4:0]  e_hold, e_bub;
  logic        e_redir;
  logic [15:0] e_tgt;
  int          n_mode;
  logic        n_pend;
  logic [15:0] n_tgt;

  typedef struct {
    logic        r, im, dm, lu, br;
    logic [15:0] t;
    logic [4:0]  stall;   // {pc, if_id, id_exe, exe_mem, mem_wb}
    logic [3:0]  flush;   // {if_id, id_exe, exe_mem, mem_wb}
    logic        redir;
    logic        chk_tgt;
    logic [15:0] tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] dut_stall();
    return {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, stall_mem_wb};
  endfunction

  function automatic logic [3:0] dut_flush();
    return {flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  task automatic model_eval();
    logic        want;
    logic [15:0] where;
    e_hold = '0; e_bub = '0; e_redir = 1'b0; e_tgt = '0;
    n_mode = m_mode; n_pend = m_pend; n_tgt = m_tgt;
    if (reset) begin
      n_mode = M_RUN; n_pend = 1'b0; n_tgt = '0;
    end else if (m_mode == M_IDRAIN) begin
      e_bub[1] = 1'b1;
      if (imem_stall) e_hold[0] = 1'b1;
      else begin e_redir = 1'b1; e_tgt = m_tgt; n_mode = M_RUN; end
    end else if (dmem_stall) begin
      e_hold[3:0] = 4'hF; e_bub[4] = 1'b1; n_mode = M_DWAIT;
      if (br_taken) begin n_pend = 1'b1; n_tgt = br_target; end
    end else begin
      want  = br_taken | m_pend;
      where = br_taken ? br_target : m_tgt;
      n_pend = 1'b0; n_mode = M_RUN;
      if (want) begin
        e_bub[3:1] = 3'b111;
        if (imem_stall) begin e_hold[0] = 1'b1; n_tgt = where; n_mode = M_IDRAIN; end
        else begin e_redir = 1'b1; e_tgt = where; end
      end else if (load_use) begin
        e_hold[1:0] = 2'b11; e_bub[2] = 1'b1;
      end else if (imem_stall) begin
        e_hold[0] = 1'b1; e_bub[1] = 1'b1;
      end
    end
  endtask

  function automatic logic [4:0] exp_stall();
    return {e_hold[0], e_hold[1], e_hold[2], e_hold[3], e_hold[4]};
  endfunction

  function automatic logic [3:0] exp_flush();
    return {e_bub[1], e_bub[2], e_bub[3], e_bub[4]};
  endfunction

  // Drive one cycle of inputs, then evaluate the model at the negedge sample point
  task automatic step(input logic r, im, dm, lu, br, input logic [15:0] t);
    reset = r; imem_stall = im; dmem_stall = dm; load_use = lu; br_taken = br; br_target = t;
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    if (reset) begin m_stalls = 0; m_squash = 0; end
    else begin m_stalls += int'(e_hold[0]); m_squash += int'(e_redir); end
    m_mode = n_mode; m_pend = n_pend; m_tgt = n_tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [4:0] s, input logic [3:0] f,
                           input logic rd, input logic ct, input logic [15:0] t);
    cmp({name, "_stall"}, 32'(dut_stall()), 32'(s));
    cmp({name, "_flush"}, 32'(dut_flush()), 32'(f));
    cmp({name, "_redir"}, 32'(pc_redirect), 32'(rd));
    if (ct) cmp({name, "_target"}, 32'(pc_target), 32'(t));
  endtask

  task automatic check_perf(input string name);
`ifdef PIPE_CTRL_PERF_EN
    cmp({name, "_stall_cycles"}, 32'(stall_cycles), 32'(m_stalls % (1 << CNT_W)));
    cmp({name, "_squash_count"}, 32'(squash_count), 32'(m_squash % (1 << CNT_W)));
`else
    cmp({name, "_stall_cycles"}, 32'(stall_cycles), 32'd0);
    cmp({name, "_squash_count"}, 32'(squash_count), 32'd0);
`endif
  endtask

  function automatic vec_t mk(input logic r, im, dm, lu, br, input logic [15:0] t,
                              input logic [4:0] s, input logic [3:0] f, input logic rd,
                              input logic ct, input logic [15:0] et);
    vec_t v;
    v.r = r; v.im = im; v.dm = dm; v.lu = lu; v.br = br; v.t = t;
    v.stall = s; v.flush = f; v.redir = rd; v.chk_tgt = ct; v.tgt = et;
    return v;
  endfunction

  initial begin
    reset = 1'b1; imem_stall = 1'b1; dmem_stall = 1'b1; load_use = 1'b1;
    br_taken = 1'b1; br_target = 16'hFFFF;

    // Consecutive cycles: reset, load-use, branch, branch during I-miss, branch during D-miss
    vecs.push_back(mk(1,1,1,1,1,16'hFFFF, 5'b00000, 4'b0000, 0, 1, 16'h0000));
    vecs.push_back(mk(1,1,1,1,1,16'hFFFF, 5'b00000, 4'b0000, 0, 1, 16'h0000));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,0,1,0,16'h0000, 5'b11000, 4'b0100, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,0,0,1,16'h3000, 5'b00000, 4'b1110, 1, 1, 16'h3000));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0,1,0,0,1,16'h1234, 5'b10000, 4'b1110, 0, 0, 16'h0000));
    vecs.push_back(mk(0,1,0,0,0,16'h0000, 5'b10000, 4'b1000, 0, 0, 16'h0000));
    vecs.push_back(mk(0,1,0,0,0,16'h0000, 5'b10000, 4'b1000, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b1000, 1, 1, 16'h1234));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b0000, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 5'b11110, 4'b0001, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,1,0,1,16'h0040, 5'b11110, 4'b0001, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 5'b11110, 4'b0001, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 5'b11110, 4'b0001, 0, 0, 16'h0000));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b1110, 1, 1, 16'h0040));
    vecs.push_back(mk(0,0,0,0,0,16'h0000, 5'b00000, 4'b0000, 0, 0, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].im, vecs[i].dm, vecs[i].lu, vecs[i].br, vecs[i].t);
      check_out($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].redir,
                vecs[i].chk_tgt, vecs[i].tgt);
      if (i == 2) check_perf("post_reset");
      tick();
    end
    check_perf("scenarios");

    // Reset while IDRAIN holds a target: redirect must be dropped
    step(0,1,0,0,1,16'hABCD); check_out("idr_enter", 5'b10000, 4'b1110, 0, 0, 16'h0); tick();
    step(0,1,1,1,1,16'h7777); check_out("idr_ignore", 5'b10000, 4'b1000, 0, 0, 16'h0); tick();
    step(1,1,0,0,0,16'h0000); check_out("idr_reset", 5'b00000, 4'b0000, 0, 1, 16'h0); tick();
    step(0,0,0,0,0,16'h0000); check_out("idr_dropped", 5'b00000, 4'b0000, 0, 0, 16'h0); tick();

    // Reset in DWAIT with a buffered branch
    step(0,0,1,0,1,16'h5555); check_out("dw_enter", 5'b11110, 4'b0001, 0, 0, 16'h0); tick();
    step(1,0,1,0,0,16'h0000); check_out("dw_reset", 5'b00000, 4'b0000, 0, 1, 16'h0); tick();
    step(0,0,0,0,0,16'h0000); check_out("dw_dropped", 5'b00000, 4'b0000, 0, 0, 16'h0); tick();

    // A fresh br_taken at D-miss release wins over the buffered target
    step(0,0,1,0,1,16'h1111); tick();
    step(0,0,0,0,1,16'h2222); check_out("dw_override", 5'b00000, 4'b1110, 1, 1, 16'h2222); tick();

    // Buffered branch released into an I-miss goes through IDRAIN
    step(0,0,1,0,1,16'h0777); tick();
    step(0,1,0,0,0,16'h0000); check_out("dw_to_idr", 5'b10000, 4'b1110, 0, 0, 16'h0); tick();
    step(0,0,0,0,0,16'h0000); check_out("dw_idr_redir", 5'b00000, 4'b1000, 1, 1, 16'h0777); tick();
    check_perf("corners");

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 16'($urandom));
      check_out("rnd", exp_stall(), exp_flush(), e_redir, e_redir | reset, e_tgt);
      if (c % 500 == 499) check_perf("rnd");
      tick();
    end
    step(0,0,0,0,0,16'h0000);
    check_perf("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
